decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue_if.sv | 38 +++
 rtl/decode_issue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_if.sv
// Decode/issue stage bundle: fetch-side instruction offer, write-back port,
// and the issue port toward the ALU.
//
// Handshake rules (both the in_* and ex_* pairs): a transfer happens on a
// rising edge where valid and ready are both high; the producer holds
// valid and its payload stable until that edge, and ready may depend
// combinationally on valid/payload of the same cycle.
interface decode_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_x;
    logic [31:0] ex_y;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [4:0]  ex_rd;
    logic        illegal;

    // Environment side: offers instructions, write-backs and ALU readiness.
    modport master (
        output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, ex_ready,
        input  in_ready, ex_valid, ex_x, ex_y, ex_funct3, ex_funct7, ex_rd, illegal
    );

    // Decode/issue stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, ex_ready,
        output in_ready, ex_valid, ex_x, ex_y, ex_funct3, ex_funct7, ex_rd, illegal
    );
endinterface

// File: rtl/decode_issue.sv
// RV32I integer decode and issue stage: decodes OP / OP-IMM / LUI / AUIPC,
// reads the register file with write-back bypass, tracks outstanding
// destinations in a pending-bit scoreboard and issues ALU operands through
// a single output register slot.
module decode_issue #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    decode_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];

    // Architectural state; entry 0 is never written so it always reads 0.
    logic [XLEN-1:0] regs [0:31];
    logic [31:0]     pending;
    logic [31:0]     pending_next;

    // Output slot registers
    logic            ex_valid_q;
    logic [XLEN-1:0] ex_x_q;
    logic [XLEN-1:0] ex_y_q;
    logic [2:0]      ex_funct3_q;
    logic [6:0]      ex_funct7_q;
    logic [4:0]      ex_rd_q;
    logic            illegal_q;

    // Decode results
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] dec_x;
    logic [XLEN-1:0] dec_y;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            hazard;
    logic            accept;
    logic            issue;
    logic            reject;

    // Register read with same-cycle write-back bypass; x0 reads zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            if (bus.wb_en && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
            else                                  rs1_val = regs[rs1];
        end
        if (rs2 != 5'd0) begin
            if (bus.wb_en && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
            else                                  rs2_val = regs[rs2];
        end
    end

    // A source blocks while its producer is outstanding, unless the value
    // is arriving on the write-back port this very cycle.
    always_comb begin
        rs1_busy = (rs1 != 5'd0) && pending[rs1] && !(bus.wb_en && (bus.wb_rd == rs1));
        rs2_busy = (rs2 != 5'd0) && pending[rs2] && !(bus.wb_en && (bus.wb_rd == rs2));
    end

    // Instruction decode: legality, operand selection and ALU controls.
    always_comb begin
        legal      = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec_x      = '0;
        dec_y      = '0;
        dec_funct3 = 3'b000;
        dec_funct7 = F7_ZERO;
        case (opcode)
            OPC_OP: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_x      = rs1_val;
                dec_y      = rs2_val;
                dec_funct3 = funct3;
                dec_funct7 = funct7;
                legal      = (funct7 == F7_ZERO) ||
                             ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                use_rs1    = 1'b1;
                dec_x      = rs1_val;
                dec_y      = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                dec_funct3 = funct3;
                legal      = 1'b1;
                case (funct3)
                    3'b001: begin
                        legal = (funct7 == F7_ZERO);
                        dec_y = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                    end
                    3'b101: begin
                        legal      = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_y      = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                        dec_funct7 = bus.in_instr[30] ? F7_ALT : F7_ZERO;
                    end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                dec_y = {bus.in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                dec_x = bus.in_pc;
                dec_y = {bus.in_instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    // Acceptance: the slot must be free; only legal instructions wait on hazards.
    always_comb begin
        hazard       = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);
        bus.in_ready = rst_n && (!ex_valid_q || bus.ex_ready) && !(legal && hazard);
        accept       = bus.in_valid && bus.in_ready;
        issue        = accept && legal;
        reject       = accept && !legal;
    end

    // Scoreboard next state: clear on write-back first so a same-index set wins.
    always_comb begin
        pending_next = pending;
        if (bus.wb_en) pending_next[bus.wb_rd] = 1'b0;
        if (issue && (rd != 5'd0)) pending_next[rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    // Register file write port; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Issue slot: load on legal accept, hold under backpressure, drain otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_x_q      <= '0;
            ex_y_q      <= '0;
            ex_funct3_q <= 3'b000;
            ex_funct7_q <= 7'b0000000;
            ex_rd_q     <= 5'd0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= reject;
            if (issue) begin
                ex_valid_q  <= 1'b1;
                ex_x_q      <= dec_x;
                ex_y_q      <= dec_y;
                ex_funct3_q <= dec_funct3;
                ex_funct7_q <= dec_funct7;
                ex_rd_q     <= rd;
            end else if (bus.ex_ready) begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_x      = ex_x_q;
    assign bus.ex_y      = ex_y_q;
    assign bus.ex_funct3 = ex_funct3_q;
    assign bus.ex_funct7 = ex_funct7_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.illegal   = illegal_q;
endmodule
